// File: rtl/conv_ctrl.sv
// conv_ctrl: walks a 3x3 window over the image RAM,
// loads each window into the conv unit and stores the clamped result.
module conv_ctrl #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int ADDR_W     = 6,
  parameter int OUT_ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  conv_load,
  output logic [1:0]            conv_row,
  output logic [1:0]            conv_col,
  output logic [7:0]            conv_data,
  input  logic [7:0]            conv_out,
  output logic                  wr_en,
  output logic [OUT_ADDR_W-1:0] wr_addr,
  output logic [7:0]            wr_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_COMP  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [3:0]            k_q, k_d;
  logic [ADDR_W-1:0]     r_q, r_d;
  logic [ADDR_W-1:0]     c_q, c_d;
  logic [OUT_ADDR_W-1:0] oidx_q, oidx_d;
  logic [1:0]            row_q, row_d;
  logic [1:0]            col_q, col_d;
  logic [7:0]            data_q, data_d;

  logic [3:0]        km1;
  logic              ld;
  logic              last_c;
  logic              last_r;
  logic [ADDR_W-1:0] a_row;
  logic [ADDR_W-1:0] a_col;
  logic [ADDR_W-1:0] addr;

  function automatic logic [1:0] div3(input logic [3:0] v);
    if (v >= 4'd6) return 2'd2;
    else if (v >= 4'd3) return 2'd1;
    else return 2'd0;
  endfunction

  function automatic logic [1:0] mod3(input logic [3:0] v);
    logic [3:0] t;
    t = v - {2'b00, div3(v)} * 4'd3;
    return t[1:0];
  endfunction

  // Window geometry, read address and load element decode
  always_comb begin
    km1    = k_q - 4'd1;
    ld     = (state_q == S_LOAD) && (k_q != 4'd0);
    last_c = (c_q == ADDR_W'(IMG_W - 3));
    last_r = (r_q == ADDR_W'(IMG_H - 3));
    a_row  = r_q + ADDR_W'(div3(k_q));
    a_col  = c_q + ADDR_W'(mod3(k_q));
    addr   = a_row * ADDR_W'(IMG_W) + a_col;
  end

  // Next-state logic for the FSM, window origin and held conv fields
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    c_d     = c_q;
    oidx_d  = oidx_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    if (ld) begin
      row_d  = div3(km1);
      col_d  = mod3(km1);
      data_d = rd_data;
    end
    unique case (state_q)
      S_IDLE: begin
        r_d    = '0;
        c_d    = '0;
        oidx_d = '0;
        k_d    = '0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (k_q == 4'd9) begin
          k_d     = '0;
          state_d = S_COMP;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_COMP: state_d = S_WRITE;
      S_WRITE: begin
        if (last_c && last_r) begin
          state_d = S_DONE;
        end else begin
          oidx_d  = oidx_q + OUT_ADDR_W'(1);
          k_d     = '0;
          state_d = S_LOAD;
          if (last_c) begin
            c_d = '0;
            r_d = r_q + ADDR_W'(1);
          end else begin
            c_d = c_q + ADDR_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; everything forced low while reset is asserted
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    conv_load = ld;
    conv_row  = row_d;
    conv_col  = col_d;
    conv_data = data_d;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    unique case (state_q)
      S_LOAD: begin
        busy = 1'b1;
        if (k_q <= 4'd8) begin
          rd_en   = 1'b1;
          rd_addr = addr;
        end
      end
      S_COMP:  busy = 1'b1;
      S_WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = oidx_q;
        wr_data = conv_out;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    if (reset) begin
      busy      = 1'b0;
      done      = 1'b0;
      rd_en     = 1'b0;
      rd_addr   = '0;
      conv_load = 1'b0;
      conv_row  = '0;
      conv_col  = '0;
      conv_data = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      oidx_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      c_q     <= c_d;
      oidx_q  <= oidx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: 4x4 frames through conv_ctrl with a behavioural
// RAM and vertical-gradient conv model; scoreboard checks writes/done.
module tb_conv_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       conv_load;
  logic [1:0] conv_row, conv_col;
  logic [7:0] conv_data;
  logic [7:0] conv_out;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];

  logic [7:0] img [16];
  logic [7:0] win [0:2][0:2];

  conv_ctrl #(
    .IMG_W(4), .IMG_H(4), .ADDR_W(4), .OUT_ADDR_W(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .conv_load(conv_load), .conv_row(conv_row),
    .conv_col(conv_col), .conv_data(conv_data),
    .conv_out(conv_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rd_en) rd_data <= img[rd_addr];

  always @(posedge clk) begin : conv_model
    int s;
    if (conv_load) begin
      if (conv_row < 2'd3 && conv_col < 2'd3)
        win[conv_row][conv_col] <= conv_data;
    end else begin
      s = int'(win[0][0]) + 2 * int'(win[0][1]) + int'(win[0][2])
        - int'(win[2][0]) - 2 * int'(win[2][1]) - int'(win[2][2]);
      if (s < 0) conv_out <= 8'd0;
      else if (s > 255) conv_out <= 8'd255;
      else conv_out <= 8'(s);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int outs();
    return int'({busy, done, rd_en, rd_addr, conv_load, conv_row,
                 conv_col, conv_data, wr_en, wr_addr, wr_data});
  endfunction

  // Monitor: pop expected writes / done pulses as the DUT presents them
  always @(negedge clk) begin
    wr_t e;
    int  dc;
    if (wr_en) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", int'(wr_addr), -1);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", int'(wr_addr), int'(e.a));
        chk("wr_data", int'(wr_data), int'(e.d));
        chk("wr_cycle", cyc, e.c);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        chk("unexpected_done", cyc, -1);
      end else begin
        dc = exp_done.pop_front();
        chk("done_cycle", cyc, dc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic set_img(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       img[i] = 8'd50;
        1:       img[i] = (i < 4) ? 8'd200 : 8'd0;
        default: img[i] = (i >= 12) ? 8'd200 : 8'd0;
      endcase
    end
  endtask

  task automatic push_wr(input int a, input int d, input int c);
    wr_t e;
    e.a = a[1:0];
    e.d = d[7:0];
    e.c = c;
    exp_wr.push_back(e);
  endtask

  task automatic push_frame(input int c0, input int d0, input int d1,
                            input int d2, input int d3);
    push_wr(0, d0, c0 + 12);
    push_wr(1, d1, c0 + 24);
    push_wr(2, d2, c0 + 36);
    push_wr(3, d3, c0 + 48);
    exp_done.push_back(c0 + 49);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain(input string nm);
    chk(nm, exp_wr.size() + exp_done.size(), 0);
    exp_wr.delete();
    exp_done.delete();
  endtask

  initial begin
    int c0;
    logic [3:0] tbl [9];
    tbl = '{4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
    reset = 1'b1;
    start = 1'b0;
    set_img(0);
    repeat (3) step();
    chk("reset_outputs", outs(), 0);
    reset = 1'b0;
    step();
    chk("idle_outputs", outs(), 0);

    set_img(0);
    c0 = cyc;
    push_frame(c0, 0, 0, 0, 0);
    pulse_start();
    chk("busy_first", int'(busy), 1);
    chk("rd_en_first", int'(rd_en), 1);
    chk("rd_addr_first", int'(rd_addr), 0);
    wait_until(c0 + 55);
    drain("flat_drain");

    set_img(1);
    c0 = cyc;
    push_frame(c0, 255, 255, 0, 0);
    pulse_start();
    wait_until(c0 + 55);
    drain("row0_drain");

    set_img(2);
    c0 = cyc;
    push_frame(c0, 0, 0, 0, 0);
    pulse_start();
    for (int j = 0; j < 9; j++) begin
      wait_until(c0 + 37 + j);
      chk("win11_rd_addr", int'(rd_addr), int'(tbl[j]));
    end
    wait_until(c0 + 55);
    drain("row3_drain");

    set_img(1);
    c0 = cyc;
    push_wr(0, 255, c0 + 12);
    pulse_start();
    wait_until(c0 + 18);
    reset = 1'b1;
    #1;
    chk("reset_mid_outputs", outs(), 0);
    step();
    reset = 1'b0;
    #1;
    chk("post_reset_outputs", outs(), 0);
    wait_until(c0 + 60);
    drain("reset_drain");
    c0 = cyc;
    push_frame(c0, 255, 255, 0, 0);
    pulse_start();
    wait_until(c0 + 55);
    drain("restart_drain");

    set_img(0);
    c0 = cyc;
    push_frame(c0, 0, 0, 0, 0);
    pulse_start();
    wait_until(c0 + 20);
    pulse_start();
    wait_until(c0 + 60);
    chk("busy_idle", int'(busy), 0);
    drain("busy_start_drain");

    set_img(1);
    c0 = cyc;
    push_frame(c0, 255, 255, 0, 0);
    push_frame(c0 + 50, 255, 255, 0, 0);
    start = 1'b1;
    wait_until(c0 + 99);
    start = 1'b0;
    wait_until(c0 + 110);
    chk("b2b_idle", int'(busy), 0);
    drain("b2b_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_ctrl.md
# conv_ctrl

Sequencing controller for the 3x3 conv unit. On `start` it scans a stored IMG_W x IMG_H 8-bit image with a 3x3 window, without padding. For each window it:
- reads the nine pixels from a synchronous image RAM,
- loads them into the conv unit,
- triggers one compute cycle,
- writes the clamped 0..255 result into an output RAM.

It sits between the image/result memories and the conv instance, and is the only driver of the conv unit's load port.

## Interface
- IMG_W, 8, image width in pixels (>= 3)
- IMG_H, 8, image height in pixels (>= 3)
- ADDR_W, 6, image RAM address width; must hold IMG_W*IMG_H-1
- OUT_ADDR_W, 6, result RAM address width; must hold (IMG_W-2)*(IMG_H-2)-1
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after `start` is accepted until DONE
- done  out  1  one-cycle pulse in DONE
- rd_en  out  1  image RAM read strobe
- rd_addr  out  ADDR_W  image RAM address; RAM returns `rd_data` one cycle later
- rd_data  in  8  image RAM read data
- conv_load  out  1  drives conv `data_in`; 1 = load element, 0 = compute
- conv_row  out  2  drives conv `row_in`
- conv_col  out  2  drives conv `col_in`
- conv_data  out  8  drives conv `data`; equals `rd_data` during load
- conv_out  in  8  conv `out`; registered on the compute edge
- wr_en  out  1  result RAM write strobe
- wr_addr  out  OUT_ADDR_W  result RAM address
- wr_data  out  8  result RAM write data

## Operation
States and transitions:
- IDLE: moves to LOAD on `start`. Clears the window origin and the output index. The rule `r=0, c=0, oidx=0` holds.
- LOAD: 10 cycles, step counter k = 0..9.
  - For k <= 8: rd_en=1, rd_addr = (r + k/3)*IMG_W + (c + k%3).
  - For k >= 1: conv_load=1, conv_row=(k-1)/3, conv_col=(k-1)%3, conv_data=rd_data.
  - On k=9, move to COMPUTE.
- COMPUTE: 1 cycle. conv_load=0 and rd_en=0. The conv unit registers `out` at the end of this cycle. Moves to WRITE.
- WRITE: 1 cycle. wr_en=1, wr_addr=oidx, wr_data=conv_out.
  - If c == IMG_W-3 and r == IMG_H-3, move to DONE.
  - Otherwise oidx++. If c == IMG_W-3, set c=0 and r++; else c++. Then move to LOAD with k=0.
- DONE: 1 cycle with done=1, then IDLE.

Window order, arithmetic and output defaults:
- Windows are visited in row-major order. oidx = r*(IMG_W-2) + c, and the last oidx is (IMG_W-2)*(IMG_H-2)-1.
- Address arithmetic is unsigned, with no wrap, because the parameters guarantee in-range addresses.
- Outputs not listed for a state are 0, except that conv_row, conv_col and conv_data hold their last values.

Reset and boundary cases:
- Reset (any state, including mid-LOAD or WRITE) forces IDLE at the next edge. Every output is 0 during and after reset, and no write is issued after reset is sampled.
- `start` is ignored when not in IDLE, including during DONE.
- `start` held high in IDLE immediately after DONE begins a new frame.
- The conv unit has its own `reset`. The controller never relies on conv contents surviving across windows, because all nine elements are reloaded each window.

## Timing
- `start` is sampled at edge E0, with state IDLE → LOAD. busy=1 and the first rd_en occur in the cycle after E0.
- Per window: 10 LOAD + 1 COMPUTE + 1 WRITE = 12 cycles.
- The first wr_en is high in the 12th cycle after E0.
- Frame latency from E0 to done is 12*(IMG_W-2)*(IMG_H-2) + 1 cycles (433 for 8x8). IDLE follows one cycle later.
- Read-to-load latency is exactly 1 cycle: the data for element k-1 is loaded in LOAD step k.
- wr_data equals the conv result of the window whose nine loads ended in the immediately preceding LOAD.

## Test plan
All scenarios use IMG_W=IMG_H=4 with a real conv instance and behavioural synchronous RAMs.
- Flat image, all pixels 50, then pulse `start` → 4 writes to oidx 0..3, each with wr_data=0. done pulses at cycle 49 after E0.
- Row 0 = 200, other rows 0 → oidx0=255 and oidx1=255 (clamped from 800). oidx2=0 and oidx3=0.
- Row 3 = 200, other rows 0 → all four outputs are 0 (negative result clamped). Check that rd_addr for window (1,1) steps through 5,6,7,9,10,11,13,14,15.
- Assert `reset` during LOAD step 5 of the second window → IDLE and all outputs 0 the next cycle. No further wr_en. A fresh `start` then reproduces the full 4-write result.
- Pulse `start` again while busy, at cycle 20 → ignored: exactly 4 writes occur and exactly one done pulse.
- Hold `start` high continuously → two back-to-back frames. done pulses at cycle 49 and again at cycle 49 + 50, with identical write sequences.
